esfa_vector_fetch: RTL and testbench
====================================

ESFA_VECTOR_FETCH -- requirements
Module: esfa_vector_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, ROM address width.
REQ-002 SHALL have parameter ROM_LATENCY, default 2, ROM read latency in cycles (legal 1..3).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries (power of two, at least ROM_LATENCY+1).
REQ-004 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  in  1  single-cycle pulse that begins a program run at address 0.
REQ-007 SHALL have ports rom_addr  out  ADDR_W  ROM address, and rom_en  out  1  read strobe.
REQ-008 SHALL have port rom_data  in  40  ROM word, valid ROM_LATENCY cycles after its rom_en.
REQ-009 SHALL have ports vec_valid  out  1  and vec_ready  in  1  (downstream handshake).
REQ-010 SHALL have decoded outputs vec_is_mutating, vec_expected_bool, vec_end and vec_is_metadata (1 bit each, word bits 0..3), plus vec_new_index, vec_new_value, vec_metadata and vec_selector (8 bits each, word bits 15:8, 23:16, 31:24 and 39:32).
REQ-011 SHALL have port vec_addr  out  ADDR_W  ROM address of the presented word.
REQ-012 SHALL have ports busy  out  1, done  out  1, overflow  out  1, and vec_count  out  16  (vectors accepted downstream).

Function
REQ-013 SHALL implement FSM IDLE -> FETCH on start; FETCH -> DRAIN once an end word is captured or the last address is issued; DRAIN -> DONE when the end word is accepted; DONE -> FETCH on start.
REQ-014 SHALL ignore start in FETCH and DRAIN.
REQ-015 SHALL, in FETCH, assert rom_en with rom_addr incrementing by 1 per issue, only when (reads in flight + FIFO occupancy) < FIFO_DEPTH; data is never dropped.
REQ-016 SHALL track in-flight reads with a ROM_LATENCY-deep valid/address tag shift register, and write the returning word plus tag address into the FIFO.
REQ-017 SHALL stop issuing in the cycle the end bit (bit 2) is captured, and discard every in-flight word whose address exceeds the end word's.
REQ-018 SHALL deliver the end word itself downstream with vec_end=1.
REQ-019 SHALL issue address 2^ADDR_W-1 as the final read when no end bit has been seen, force vec_end=1 on that word, and set overflow; the address never wraps to 0 within a run.
REQ-020 SHALL present the FIFO head combinationally on the vec_* outputs; a transfer occurs when vec_valid and vec_ready are both high.
REQ-021 SHALL hold vec_* stable while vec_valid=1 and vec_ready=0.
REQ-022 SHALL allow a FIFO write and read in the same cycle when full, with no loss.
REQ-023 SHALL increment vec_count (saturating at 0xFFFF) once per transfer, and clear it on start.
REQ-024 SHALL assert busy in FETCH and DRAIN, and assert done only in DONE, where it is held until the next start.
REQ-025 SHALL give first-vector latency from start of ROM_LATENCY+2 cycles to vec_valid when vec_ready is held high.
REQ-026 SHALL sustain one vector per cycle at vec_ready=1.
REQ-027 SHALL clear overflow on start.

Reset
REQ-028 SHALL, on reset, immediately return to IDLE and drive rom_en=0, rom_addr=0, vec_valid=0, busy=0, done=0, overflow=0 and vec_count=0, with FIFO and tag pipeline emptied.
REQ-029 SHALL drop all in-flight reads when reset is asserted mid-run, and accept no returning data as valid after reset.

Structure
REQ-030 SHALL take the word bit positions and the 40-bit word width from the shared esfa package constants, reused by the benchmark harness.
REQ-031 SHALL instantiate a single sub-module, esfa_sync_fifo (parameter width and depth, with full/empty/count), for the output buffer.

Verification
REQ-032 SHALL pass this scenario: ROM words 0..4 with the end bit at address 4, vec_ready=1 -> 5 vectors at addresses 0..4, the last with vec_end=1, done=1, vec_count=5.
REQ-033 SHALL pass this scenario: same ROM, vec_ready low for 10 cycles after start -> rom_en stops after 4 outstanding plus buffered, and no vector is lost or reordered on release.
REQ-034 SHALL pass this scenario: end bit at address 1 with ROM_LATENCY=2 -> addresses 2 and 3 are fetched but never presented; vec_count=2.
REQ-035 SHALL pass this scenario: ADDR_W=3 with no end bit -> 8 vectors, the address-7 vector has vec_end=1, overflow=1.
REQ-036 SHALL pass this scenario: reset asserted at cycle 3 of a run -> vec_valid=0 and busy=0 in that cycle; a new start replays from address 0.
REQ-037 SHALL pass this scenario: start pulsed during FETCH -> ignored, and the address sequence is uninterrupted.

Source files
------------

// File: rtl/esfa_pkg.sv
// Shared ESFA vector word layout and fetch-controller types, reused by the
// benchmark harness so both sides agree on bit positions.
package esfa_pkg;

  localparam int WORD_W        = 40;
  localparam int FIELD_W       = 8;

  localparam int BIT_MUTATING  = 0;
  localparam int BIT_EXPECTED  = 1;
  localparam int BIT_END       = 2;
  localparam int BIT_METADATA  = 3;

  localparam int NEW_INDEX_LSB = 8;
  localparam int NEW_VALUE_LSB = 16;
  localparam int METADATA_LSB  = 24;
  localparam int SELECTOR_LSB  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_e;

  // Returns the word with its end flag forced when force_end is set.
  function automatic logic [WORD_W-1:0] set_end_bit(input logic [WORD_W-1:0] w,
                                                    input logic              force_end);
    logic [WORD_W-1:0] r;
    r          = w;
    r[BIT_END] = w[BIT_END] | force_end;
    return r;
  endfunction

endpackage

// File: rtl/esfa_sync_fifo.sv
// Synchronous FIFO with a combinational head; a write is accepted while full
// when a read happens in the same cycle.
module esfa_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_wr_s;
  logic             do_rd_s;

  assign empty   = (count_q == CW'(0));
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_rd_s = rd_en & ~empty;
  assign do_wr_s = wr_en & (~full | do_rd_s);

  // Storage array; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (do_wr_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_rd_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/esfa_vector_fetch.sv
// Streams test vectors from a fixed-latency ROM into a small output buffer
// with credit-based issue, end-of-program detection and address overflow.
module esfa_vector_fetch
  import esfa_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int ROM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic               rom_en,
  input  logic [WORD_W-1:0]  rom_data,
  output logic               vec_valid,
  input  logic               vec_ready,
  output logic               vec_is_mutating,
  output logic               vec_expected_bool,
  output logic               vec_end,
  output logic               vec_is_metadata,
  output logic [FIELD_W-1:0] vec_new_index,
  output logic [FIELD_W-1:0] vec_new_value,
  output logic [FIELD_W-1:0] vec_metadata,
  output logic [FIELD_W-1:0] vec_selector,
  output logic [ADDR_W-1:0]  vec_addr,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [15:0]        vec_count
);

  localparam int CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W   = CW + 2;
  localparam int ENTRY_W = ADDR_W + WORD_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  fetch_state_e           state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   overflow_q, overflow_d;
  logic [15:0]            vec_count_q, vec_count_d;
  logic [ROM_LATENCY-1:0] tag_v_q, tag_v_d;
  logic [ADDR_W-1:0]      tag_a_q [ROM_LATENCY];
  logic [ADDR_W-1:0]      tag_a_d [ROM_LATENCY];

  logic [OCC_W-1:0]       inflight_s;
  logic [OCC_W-1:0]       occ_s;
  logic                   issue_s;
  logic                   pop_s;
  logic                   cap_v_s;
  logic                   cap_last_s;
  logic                   cap_end_s;
  logic [ADDR_W-1:0]      cap_addr_s;
  logic [WORD_W-1:0]      cap_word_s;
  logic [WORD_W-1:0]      head_word_s;
  logic [ENTRY_W-1:0]     fifo_wr_data_s;
  logic [ENTRY_W-1:0]     fifo_rd_data_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [CW-1:0]          fifo_count_s;
  logic                   unused_head_s;

  // The returning word lines up with the oldest tag stage.
  assign cap_v_s        = tag_v_q[ROM_LATENCY-1];
  assign cap_addr_s     = tag_a_q[ROM_LATENCY-1];
  assign cap_last_s     = (cap_addr_s == LAST_ADDR);
  assign cap_word_s     = set_end_bit(rom_data, cap_last_s);
  assign cap_end_s      = cap_v_s & cap_word_s[BIT_END];
  assign fifo_wr_data_s = {cap_addr_s, cap_word_s};

  assign vec_valid = ~fifo_empty_s;
  assign pop_s     = vec_valid & vec_ready;
  assign issue_s   = (state_q == ST_FETCH) && (occ_s < OCC_W'(FIFO_DEPTH));
  assign rom_en    = issue_s;
  assign rom_addr  = addr_q;

  // Outstanding reads plus buffered words, less the one leaving this cycle.
  always_comb begin
    inflight_s = {OCC_W{1'b0}};
    for (int i = 0; i < ROM_LATENCY; i++) begin
      inflight_s = inflight_s + OCC_W'(tag_v_q[i]);
    end
    occ_s = inflight_s + OCC_W'(fifo_count_s) - OCC_W'(pop_s);
  end

  // Tag pipeline; an end capture discards every younger read, including one issued now.
  always_comb begin
    tag_v_d = tag_v_q;
    tag_a_d = tag_a_q;
    if (cap_end_s) begin
      tag_v_d = {ROM_LATENCY{1'b0}};
    end else begin
      tag_v_d[0] = issue_s;
      tag_a_d[0] = addr_q;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        tag_v_d[i] = tag_v_q[i-1];
        tag_a_d[i] = tag_a_q[i-1];
      end
    end
  end

  // Run control: state, issue address, overflow flag and transfer counter.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (pop_s && (vec_count_q != 16'hFFFF)) begin
      vec_count_d = vec_count_q + 16'd1;
    end else begin
      vec_count_d = vec_count_q;
    end
    if (cap_v_s && cap_last_s && !rom_data[BIT_END]) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_FETCH;
          addr_d      = {ADDR_W{1'b0}};
          overflow_d  = 1'b0;
          vec_count_d = 16'd0;
        end else begin
          state_d = state_q;
        end
      end
      ST_FETCH: begin
        if (issue_s && (addr_q != LAST_ADDR)) begin
          addr_d = addr_q + ADDR_W'(1);
        end else begin
          addr_d = addr_q;
        end
        if (cap_end_s || (issue_s && (addr_q == LAST_ADDR))) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (pop_s && vec_end) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and tag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= {ADDR_W{1'b0}};
      overflow_q  <= 1'b0;
      vec_count_q <= 16'd0;
      tag_v_q     <= {ROM_LATENCY{1'b0}};
      for (int i = 0; i < ROM_LATENCY; i++) begin
        tag_a_q[i] <= {ADDR_W{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      overflow_q  <= overflow_d;
      vec_count_q <= vec_count_d;
      tag_v_q     <= tag_v_d;
      for (int i = 0; i < ROM_LATENCY; i++) begin
        tag_a_q[i] <= tag_a_d[i];
      end
    end
  end

  esfa_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst     (reset),
    .wr_en   (cap_v_s),
    .wr_data (fifo_wr_data_s),
    .rd_en   (vec_ready),
    .rd_data (fifo_rd_data_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  assign head_word_s       = fifo_rd_data_s[WORD_W-1:0];
  assign vec_addr          = fifo_rd_data_s[ENTRY_W-1:WORD_W];
  assign vec_is_mutating   = head_word_s[BIT_MUTATING];
  assign vec_expected_bool = head_word_s[BIT_EXPECTED];
  assign vec_end           = head_word_s[BIT_END];
  assign vec_is_metadata   = head_word_s[BIT_METADATA];
  assign vec_new_index     = head_word_s[NEW_INDEX_LSB +: FIELD_W];
  assign vec_new_value     = head_word_s[NEW_VALUE_LSB +: FIELD_W];
  assign vec_metadata      = head_word_s[METADATA_LSB +: FIELD_W];
  assign vec_selector      = head_word_s[SELECTOR_LSB +: FIELD_W];
  assign unused_head_s     = ^{head_word_s[7:4], fifo_full_s};

  assign busy      = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign overflow  = overflow_q;
  assign vec_count = vec_count_q;

endmodule

// File: tb/tb_esfa_vector_fetch.sv
// Randomized bench for esfa_vector_fetch: a ROM model, a program-level
// reference of the expected vector stream, and directed boundary runs.
module tb_esfa_vector_fetch;
  import esfa_pkg::*;

  localparam int AW     = 3;
  localparam int LAT    = 2;
  localparam int DEPTH  = 4;
  localparam int NWORDS = 8;

  logic              clk = 1'b0;
  logic              reset, start, rom_en, vec_valid, vec_ready;
  logic [AW-1:0]     rom_addr, vec_addr;
  logic [WORD_W-1:0] rom_data;
  logic              vec_is_mutating, vec_expected_bool, vec_end, vec_is_metadata;
  logic [7:0]        vec_new_index, vec_new_value, vec_metadata, vec_selector;
  logic              busy, done, overflow;
  logic [15:0]       vec_count;

  esfa_vector_fetch #(.ADDR_W(AW), .ROM_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
    .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_is_mutating(vec_is_mutating), .vec_expected_bool(vec_expected_bool),
    .vec_end(vec_end), .vec_is_metadata(vec_is_metadata),
    .vec_new_index(vec_new_index), .vec_new_value(vec_new_value),
    .vec_metadata(vec_metadata), .vec_selector(vec_selector),
    .vec_addr(vec_addr), .busy(busy), .done(done), .overflow(overflow),
    .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  // ROM model: data for an address sampled at an edge appears LAT cycles later.
  logic [WORD_W-1:0] rom_mem  [NWORDS];
  logic [WORD_W-1:0] rom_pipe [LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_mem[rom_addr];
    for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[LAT-1];

  typedef struct {
    logic [AW-1:0]     addr;
    logic [WORD_W-1:0] word;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_issue = 0;
  int   win_issues = 0;
  bit   win_active = 0;
  bit   exp_ovf;
  int   exp_len;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Program semantics: words run from 0 up to and including the first end
  // word; the last address terminates a program that never ends itself.
  function automatic void build_expected();
    exp_t e;
    exp_q.delete();
    exp_ovf = 1'b1;
    for (int a = 0; a < NWORDS; a++) begin
      e.addr = AW'(a);
      e.word = rom_mem[a];
      if (rom_mem[a][BIT_END]) exp_ovf = 1'b0;
      if (a == NWORDS - 1) e.word[BIT_END] = 1'b1;
      exp_q.push_back(e);
      if (e.word[BIT_END]) break;
    end
    exp_len = exp_q.size();
  endfunction

  // end_pos < 0 means the program carries no end bit at all.
  task automatic load_rom(input int end_pos);
    logic [WORD_W-1:0] w;
    for (int a = 0; a < NWORDS; a++) begin
      w = {8'($urandom), 32'($urandom)};
      if (end_pos < 0 || a < end_pos) w[BIT_END] = 1'b0;
      else if (a == end_pos) w[BIT_END] = 1'b1;
      rom_mem[a] = w;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: issue address continuity and the accepted vector stream.
  always @(negedge clk) begin
    if (!reset) begin
      if (rom_en) begin
        check("issue_addr", 64'(rom_addr), 64'(exp_issue));
        exp_issue++;
        if (win_active) win_issues++;
      end
      if (vec_valid && vec_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_vec", 64'(vec_addr), 64'hFFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("vec_addr", 64'(vec_addr), 64'(mon_e.addr));
          check("vec_fields", 64'({vec_selector, vec_metadata, vec_new_value, vec_new_index}),
                64'(mon_e.word[39:8]));
          check("vec_flags", 64'({vec_is_metadata, vec_end, vec_expected_bool, vec_is_mutating}),
                64'(mon_e.word[3:0]));
        end
      end
    end
  end

  // mode 0: ready held high, 1: random ready, 2: ready low for 10 cycles after start.
  task automatic run_program(input int end_pos, input int mode, input bit mid_start);
    int lat;
    bit done_seen;
    load_rom(end_pos);
    build_expected();
    exp_issue  = 0;
    win_issues = 0;
    win_active = (mode == 2);
    start      = 1'b1;
    vec_ready  = (mode != 2);
    lat        = -1;
    done_seen  = 1'b0;
    for (int c = 1; c < 400 && !done_seen; c++) begin
      tick();
      start = mid_start && (c == 3);
      case (mode)
        0:       vec_ready = 1'b1;
        1:       vec_ready = 1'($urandom_range(1));
        default: vec_ready = (c >= 10);
      endcase
      if (c == 10) win_active = 1'b0;
      if (vec_valid && lat < 0) lat = c;
      if (done) done_seen = 1'b1;
    end
    start = 1'b0;
    check("done_reached", 64'(done_seen), 64'd1);
    check("busy_at_done", 64'(busy), 64'd0);
    check("vec_count", 64'(vec_count), 64'(exp_len));
    check("overflow", 64'(overflow), 64'(exp_ovf));
    check("all_vectors_seen", 64'(exp_q.size()), 64'd0);
    if (mode == 0) check("first_latency", 64'(lat), 64'(LAT + 2));
    if (mode == 2 && (end_pos < 0 || end_pos >= DEPTH))
      check("issues_while_stalled", 64'(win_issues), 64'(DEPTH));
  endtask

  initial begin
    int ep, md;
    bit ms;
    reset     = 1'b1;
    start     = 1'b0;
    vec_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rom_en", 64'(rom_en), 64'd0);
    check("rst_rom_addr", 64'(rom_addr), 64'd0);
    check("rst_vec_valid", 64'(vec_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_vec_count", 64'(vec_count), 64'd0);
    reset = 1'b0;
    tick();

    run_program(4, 0, 1'b0);
    run_program(4, 2, 1'b0);
    run_program(1, 0, 1'b0);
    run_program(-1, 0, 1'b0);

    // Reset in cycle 3 of a run, then replay from address 0.
    load_rom(5);
    build_expected();
    exp_issue = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("midrst_vec_valid", 64'(vec_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_rom_en", 64'(rom_en), 64'd0);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    tick();
    run_program(5, 0, 1'b0);

    run_program(-1, 1, 1'b1);
    run_program(6, 0, 1'b1);

    for (int r = 0; r < 24; r++) begin
      ep = int'($urandom_range(NWORDS)) - 1;
      md = int'($urandom_range(2));
      ms = 1'($urandom_range(1));
      run_program(ep, md, ms);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
